// File: rtl/i2s_transmitter_if.sv
// Sample handshake from the effect chain plus the I2S link pins and status pulses.
// The master drives samples in; the transmitter (slave) drives the link.
interface i2s_transmitter_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic                    sample_valid;
  logic                    sample_ready;
  logic                    bclk;
  logic                    lrclk;
  logic                    sdata;
  logic                    underrun;
  logic                    overflow;

  modport master (
    output sample_in, sample_valid,
    input  sample_ready, bclk, lrclk, sdata, underrun, overflow
  );

  modport slave (
    input  sample_in, sample_valid,
    output sample_ready, bclk, lrclk, sdata, underrun, overflow
  );
endinterface

// File: rtl/i2s_transmitter.sv
// Mono-to-stereo I2S serializer with internally generated BCLK/LRCLK and a
// one-entry holding register between the filter handshake and the frame.
module i2s_transmitter #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_BITS    = 25,
  parameter int BCLK_HALF    = 10
) (
  input  logic               system_clock,
  input  logic               rst,
  i2s_transmitter_if.slave   bus
);
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int PW = $clog2(FRAME_BITS);
  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DW-1:0]           div_cnt_q, div_cnt_d;
  logic                    bclk_q, bclk_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
  logic [SAMPLE_WIDTH-1:0] frame_word_q, frame_word_d;
  logic                    hold_full_q, hold_full_d;
  logic                    underrun_q, underrun_d;
  logic                    overflow_q, overflow_d;

  logic                    half_end_s;
  logic                    bit_event_s;
  logic                    frame_load_s;
  logic                    sample_ready_s;
  logic                    capture_s;
  logic [PW-1:0]           pos_next_s;
  logic [PW-1:0]           slot_idx_s;

  // Divider, bit-event detection and the holding-register handshake.
  always_comb begin
    half_end_s     = (div_cnt_q == DW'(BCLK_HALF - 1));
    bit_event_s    = half_end_s && bclk_q;
    frame_load_s   = bit_event_s && (pos_q == PW'(FRAME_BITS - 1));
    sample_ready_s = !hold_full_q || frame_load_s;
    capture_s      = bus.sample_valid && sample_ready_s;

    div_cnt_d = half_end_s ? '0 : div_cnt_q + DW'(1);
    bclk_d    = half_end_s ? !bclk_q : bclk_q;

    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    frame_word_d = frame_word_q;
    // The load consumes the old entry before a same-cycle capture refills it.
    if (frame_load_s) begin
      if (hold_full_q) begin
        frame_word_d = hold_q;
        hold_full_d  = 1'b0;
      end else begin
        frame_word_d = frame_word_q;
      end
    end else begin
      frame_word_d = frame_word_q;
    end
    if (capture_s) begin
      hold_d      = bus.sample_in;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end

    underrun_d = frame_load_s && !hold_full_q;
    overflow_d = bus.sample_valid && !sample_ready_s;
  end

  // Bit position, word select and serial data, all advancing on falling BCLK.
  always_comb begin
    pos_next_s = (pos_q == PW'(FRAME_BITS - 1)) ? '0 : pos_q + PW'(1);
    slot_idx_s = (pos_next_s >= PW'(SLOT_BITS)) ? pos_next_s - PW'(SLOT_BITS) : pos_next_s;

    pos_d   = pos_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    shift_d = shift_q;
    if (bit_event_s) begin
      pos_d   = pos_next_s;
      lrclk_d = (pos_next_s >= PW'(SLOT_BITS - 1)) && (pos_next_s <= PW'(FRAME_BITS - 2));
      // Both slots reload from frame_word; at p=0 that is the freshly loaded word.
      if (slot_idx_s == '0) begin
        shift_d = frame_word_d;
        sdata_d = frame_word_d[SAMPLE_WIDTH-1];
      end else if (slot_idx_s < PW'(SAMPLE_WIDTH)) begin
        shift_d = {shift_q[SAMPLE_WIDTH-2:0], 1'b0};
        sdata_d = shift_q[SAMPLE_WIDTH-2];
      end else begin
        shift_d = shift_q;
        sdata_d = 1'b0;
      end
    end else begin
      pos_d = pos_q;
    end
  end

  // State registers; reset parks p at the last bit so the first bit event loads a frame.
  always_ff @(posedge system_clock or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      pos_q        <= PW'(FRAME_BITS - 1);
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      shift_q      <= '0;
      hold_q       <= '0;
      frame_word_q <= '0;
      hold_full_q  <= 1'b0;
      underrun_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bclk_q       <= bclk_d;
      pos_q        <= pos_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      frame_word_q <= frame_word_d;
      hold_full_q  <= hold_full_d;
      underrun_q   <= underrun_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.sample_ready = sample_ready_s;
  assign bus.bclk         = bclk_q;
  assign bus.lrclk        = lrclk_q;
  assign bus.sdata        = sdata_q;
  assign bus.underrun     = underrun_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: directed scenarios, a vector table and random offers,
// all compared against a frame-level model driven by cycle arithmetic.
module tb_i2s_transmitter;
  localparam int W = 24;
  localparam logic [49:0] LR_PAT = {24'h0, {25{1'b1}}, 1'b0};

  logic system_clock = 1'b0;
  logic rst;
  always #5 system_clock = ~system_clock;

  i2s_transmitter_if #(.SAMPLE_WIDTH(W)) bus ();

  i2s_transmitter #(.SAMPLE_WIDTH(W), .SLOT_BITS(25), .BCLK_HALF(10)) dut (
    .system_clock(system_clock),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [W-1:0] data;
    bit           exp_under;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  // frame-level model
  bit           m_full;
  logic [W-1:0] m_hold, m_last;
  logic [W-1:0] exp_words[$];
  bit           exp_under[$];
  int           exp_ovf;

  // observed link
  logic [49:0] cur_bits, cur_lr;
  logic [49:0] got_bits[$];
  logic [49:0] got_lr[$];
  bit          got_under[0:31];
  int          got_ovf, clk_err, pulse_err, stab_err;
  logic        prev_sdata, prev_lr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [49:0] frame_of(input logic [W-1:0] w);
    return {w, 1'b0, w, 1'b0};
  endfunction

  function automatic logic [49:0] got_frame(input int i);
    if (i < got_bits.size()) return got_bits[i];
    return 'x;
  endfunction

  // Upcoming edge e: frame loads happen at e = 20 + 1000k after reset release.
  task automatic model_step(input bit v, input logic [W-1:0] d);
    int e;
    bit load, ready;
    e     = cyc + 1;
    load  = (e >= 20) && ((e - 20) % 1000 == 0);
    ready = !m_full || load;
    if (load) begin
      if (m_full) m_last = m_hold;
      exp_words.push_back(m_last);
      exp_under.push_back(!m_full);
      m_full = 1'b0;
    end
    if (v) begin
      if (ready) begin
        m_hold = d;
        m_full = 1'b1;
      end else begin
        exp_ovf++;
      end
    end
  endtask

  task automatic collect();
    int p;
    if (bus.bclk !== (((cyc / 10) % 2) == 1)) clk_err++;
    if (cyc >= 30 && (cyc - 30) % 20 == 0) begin
      p = ((cyc - 30) / 20) % 50;
      cur_bits[49-p] = bus.sdata;
      cur_lr[49-p]   = bus.lrclk;
      if (p == 49) begin
        got_bits.push_back(cur_bits);
        got_lr.push_back(cur_lr);
      end
    end
    if (!(cyc >= 20 && cyc % 20 == 0)) begin
      if (bus.sdata !== prev_sdata || bus.lrclk !== prev_lr) stab_err++;
    end
    prev_sdata = bus.sdata;
    prev_lr    = bus.lrclk;
    if (bus.underrun !== 1'b0) begin
      if (cyc >= 20 && (cyc - 20) % 1000 == 0 && (cyc - 20) / 1000 < 32)
        got_under[(cyc-20)/1000] = 1'b1;
      else
        pulse_err++;
    end
    if (bus.overflow !== 1'b0) got_ovf++;
  endtask

  // Called at a falling edge; drives the next rising edge and samples after it.
  task automatic tick(input bit v, input logic [W-1:0] d);
    bus.sample_valid = v;
    bus.sample_in    = d;
    model_step(v, d);
    @(posedge system_clock);
    cyc++;
    @(negedge system_clock);
    collect();
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick(1'b0, '0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    #1;
    check("reset outputs immediate",
          {bus.bclk, bus.lrclk, bus.sdata, bus.underrun, bus.overflow, bus.sample_ready}, 6'b000001);
    repeat (n) @(negedge system_clock);
    check("reset outputs held",
          {bus.bclk, bus.lrclk, bus.sdata, bus.underrun, bus.overflow, bus.sample_ready}, 6'b000001);
    m_full = 1'b0; m_hold = '0; m_last = '0; exp_ovf = 0;
    exp_words.delete(); exp_under.delete();
    got_bits.delete(); got_lr.delete();
    for (int i = 0; i < 32; i++) got_under[i] = 1'b0;
    got_ovf = 0; clk_err = 0; pulse_err = 0; stab_err = 0;
    cur_bits = '0; cur_lr = '0; prev_sdata = 1'b0; prev_lr = 1'b0;
    cyc = 0;
    rst = 1'b0;
  endtask

  task automatic check_frames(input string name, input int n_expect);
    check($sformatf("%s frame count", name), got_bits.size(), n_expect);
    for (int i = 0; i < got_bits.size() && i < exp_words.size(); i++) begin
      check($sformatf("%s f%0d data", name, i), got_bits[i], frame_of(exp_words[i]));
      check($sformatf("%s f%0d lrclk", name, i), got_lr[i], LR_PAT);
      check($sformatf("%s f%0d underrun", name, i), got_under[i], exp_under[i]);
    end
    check($sformatf("%s overflow count", name), got_ovf, exp_ovf);
    check($sformatf("%s bclk timing", name), clk_err, 0);
    check($sformatf("%s sdata stability", name), stab_err, 0);
    check($sformatf("%s pulse timing", name), pulse_err, 0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{24'h000001, 1'b0};
    vecs[1] = '{24'hFFFFFF, 1'b0};
    vecs[2] = '{24'h800000, 1'b0};
    vecs[3] = '{24'h7FFFFF, 1'b0};
    vecs[4] = '{24'h123456, 1'b0};
    vecs[5] = '{24'hABCDEF, 1'b0};
    vecs[6] = '{24'h555555, 1'b0};
    vecs[7] = '{24'hAAAAAA, 1'b0};
    vecs[8] = '{24'h0F0F0F, 1'b0};
    vecs[9] = '{24'hC0FFEE, 1'b0};

    // Reset only: idle frames of zeros with an underrun each frame.
    do_reset(5);
    run_to(3020);
    check_frames("idle", 3);
    check("idle frame1 zero", got_frame(1), 50'h0);
    check("idle underrun f0", got_under[0], 1'b1);

    // Single sample before the first load.
    do_reset(3);
    run_to(4);
    tick(1'b1, 24'hA5C3F1);
    run_to(2020);
    check_frames("single", 2);
    check("single f0 word", got_frame(0), frame_of(24'hA5C3F1));
    check("single f0 no underrun", got_under[0], 1'b0);
    check("single f1 repeat", got_frame(1), frame_of(24'hA5C3F1));

    // Second offer while full is dropped.
    do_reset(3);
    run_to(4);
    tick(1'b1, 24'h123456);
    tick(1'b1, 24'h654321);
    run_to(2020);
    check_frames("overflow", 2);
    check("overflow pulses", got_ovf, 1);
    check("overflow f0 word", got_frame(0), frame_of(24'h123456));
    check("overflow f1 underrun", got_under[1], 1'b1);
    check("overflow f1 repeat", got_frame(1), frame_of(24'h123456));

    // Capture coinciding with the frame load.
    do_reset(3);
    run_to(99);
    tick(1'b1, 24'h800000);
    check("simul ready after capture", bus.sample_ready, 1'b0);
    run_to(1018);
    check("simul ready before load", bus.sample_ready, 1'b0);
    tick(1'b0, '0);
    check("simul ready on load", bus.sample_ready, 1'b1);
    tick(1'b1, 24'h7FFFFF);
    check("simul ready after refill", bus.sample_ready, 1'b0);
    run_to(3020);
    check_frames("simul", 3);
    check("simul f1 word", got_frame(1), frame_of(24'h800000));
    check("simul f2 word", got_frame(2), frame_of(24'h7FFFFF));
    check("simul no overflow", got_ovf, 0);

    // One sample per frame from the vector table.
    do_reset(3);
    for (int k = 0; k < 10; k++) begin
      run_to(4 + 1000 * k);
      tick(1'b1, vecs[k].data);
    end
    run_to(10020);
    check_frames("rate", 10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("rate vec%0d word", k), got_frame(k), frame_of(vecs[k].data));
      check($sformatf("rate vec%0d underrun", k), got_under[k], vecs[k].exp_under);
    end
    check("rate no overflow", got_ovf, 0);

    // Reset in the middle of the p=12 bit.
    do_reset(3);
    run_to(4);
    tick(1'b1, 24'hFFFFFF);
    run_to(275);
    check("midreset pre sdata/bclk", {bus.sdata, bus.bclk}, 2'b11);
    do_reset(3);
    run_to(2020);
    check_frames("midreset", 2);
    check("midreset f0 zero", got_frame(0), 50'h0);
    check("midreset f0 underrun", got_under[0], 1'b1);

    // Random offers at an irregular rate, judged by the model.
    do_reset(3);
    while (cyc < 8020) begin
      if ($urandom_range(0, 299) == 0) tick(1'b1, W'($urandom));
      else tick(1'b0, '0);
    end
    check_frames("random", 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serializes processed 24-bit mono samples from the wah effect chain onto a standard I2S link for an external DAC. The same sample is duplicated into the left and right slots. All logic runs on the 96 MHz `system_clock`, and BCLK/LRCLK are generated internally. A one-entry holding register decouples the filter's sample-rate handshake from the serial frame.

## Interface
- `SAMPLE_WIDTH`, default 24: data bits per sample.
- `SLOT_BITS`, default 25: BCLK periods per channel slot. Must be ≥ `SAMPLE_WIDTH`+1.
- `BCLK_HALF`, default 10: `system_clock` cycles per BCLK half-period. Defaults give BCLK = 4.8 MHz and a frame of 1000 cycles (96 kHz).
- `system_clock`  in  1  system clock, 96 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `sample_in`  in  SAMPLE_WIDTH  two's-complement sample from the filter.
- `sample_valid`  in  1  `sample_in` is valid this cycle.
- `sample_ready`  out  1  holding register can accept.
- `bclk`  out  1  I2S bit clock.
- `lrclk`  out  1  I2S word select; 0 = left, 1 = right.
- `sdata`  out  1  I2S serial data, MSB first.
- `underrun`  out  1  one-cycle pulse: a frame started with no new sample.
- `overflow`  out  1  one-cycle pulse: a sample was offered while the holding register was full and was dropped.

## Operation
- **Divider:** `div_cnt` counts 0..`BCLK_HALF`-1 and wraps. `bclk` toggles on the cycle where `div_cnt`==`BCLK_HALF`-1.
- **Bit events:** a toggle of `bclk` from 1 to 0 is a "bit event".
  - Bit position `p` (0..2·`SLOT_BITS`-1) advances on each bit event, wrapping to 0.
  - `lrclk` and `sdata` update only on bit events.
- **Frame layout** (defaults, frame of 50 bits):
  - p=0..23: left word, MSB first, then p=24 a pad bit of 0.
  - p=25..48: right word (identical value), then p=49 a pad bit of 0.
  - `lrclk`=1 for p=`SLOT_BITS`-1..2·`SLOT_BITS`-2 (24..48), otherwise 0. It therefore changes one BCLK before each MSB, per I2S.
- **Holding register:**
  - `sample_ready` = !hold_full OR frame_load this cycle.
  - `sample_valid`&&`sample_ready` captures `sample_in` and sets hold_full.
  - `sample_valid`&&!`sample_ready` raises `overflow` for one cycle. The held sample is kept and the new sample is discarded.
- **Frame load:** the bit event entering p=0.
  - If hold_full: copy the holding register to frame_word and clear hold_full.
  - If empty: keep the previous frame_word and pulse `underrun`.
  - Capture and load in the same cycle: the load consumes the old value, the new sample is captured, and hold_full remains 1.
- **Shift register:** loads from frame_word at p=0 and again at p=`SLOT_BITS`. `sdata` is shifted from its MSB and is 0 for pad positions.
- **Reset values:**
  - `bclk`=0, `lrclk`=0, `sdata`=0, `underrun`=0, `overflow`=0.
  - `div_cnt`=0, p=2·`SLOT_BITS`-1, hold_full=0, frame_word=0.
  - `sample_ready`=1.
- **Reset mid-frame:** all state returns immediately to reset values. The aborted frame is not completed.

## Timing
- After `rst` deasserts:
  - `bclk` rises on the 10th `system_clock` edge.
  - It falls on the 20th. This is the first bit event: p 49→0, first frame load.
- `sdata`/`lrclk` change only with the falling `bclk` and are stable for `BCLK_HALF` cycles on each side of the rising edge.
- Latency from sample capture to its MSB on `sdata`: from the capture cycle up to the next frame load, which is at most 1000 cycles plus one.
- `underrun`/`overflow` are registered and asserted on the cycle after the causing condition.
- `sample_ready` drops the cycle after capture and returns high on the frame-load cycle.

## Test plan
- **Reset:** hold `rst`, then release, no samples.
  - `bclk` period is 20 cycles.
  - `lrclk` period is 1000 cycles, low for 25 BCLKs and high for 25.
  - `sdata`=0.
  - `underrun` pulses once per frame, starting at cycle 20.
- **Single sample:** offer 0xA5C3F1 before the first frame load.
  - Left bits p=0..23 and right bits p=25..48 read 0xA5C3F1 MSB first, sampled on `bclk` rise.
  - p=24 and p=49 are 0.
  - No `underrun` in that frame.
- **Overflow:** offer 0x123456, then 0x654321 before the next frame load.
  - `overflow` pulses once.
  - The frame carries 0x123456.
  - The next frame shows `underrun` and repeats 0x123456.
- **Simultaneous:** assert `sample_valid` with 0x7FFFFF exactly on the frame-load cycle while holding 0x800000.
  - The frame sends 0x800000.
  - The next frame sends 0x7FFFFF.
  - No `overflow`.
- **Rate match:** offer a sample every 1000 cycles for 10 frames, including the values 0x000001 and 0xFFFFFF.
  - Every value is serialized in order.
  - No `underrun` after the first frame.
  - No `overflow`.
- **Reset mid-frame:** assert `rst` at p=12 for 3 cycles.
  - Outputs go to 0 and `sample_ready`=1.
  - Timing restarts exactly as in the Reset scenario.
